// File: rtl/ring_mem_port_if.sv
// rtl/ring_mem_port_if.sv - ring slot and memory-controller signal bundle for ring_mem_port
interface ring_mem_port_if;
  // ring slot stream
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SourceIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut;
  logic [3:0]  SourceOut;
  // read-data return ring
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  // memory controller command / data
  logic        mcCmdValid;
  logic        mcCmdReady;
  logic        mcCmdWrite;
  logic [27:0] mcCmdAddr;
  logic [31:0] mcWdata;
  logic        mcWdataPop;
  logic [31:0] mcRdata;
  logic        mcRdataValid;
  logic        wdOverflow;

  // the ring station side
  modport slave (
    input  RingIn, SlotTypeIn, SourceIn, mcCmdReady, mcWdataPop, mcRdata, mcRdataValid,
    output RingOut, SlotTypeOut, SourceOut, RDreturn, RDdest,
    output mcCmdValid, mcCmdWrite, mcCmdAddr, mcWdata, wdOverflow
  );

  // the ring / memory controller side
  modport master (
    output RingIn, SlotTypeIn, SourceIn, mcCmdReady, mcWdataPop, mcRdata, mcRdataValid,
    input  RingOut, SlotTypeOut, SourceOut, RDreturn, RDdest,
    input  mcCmdValid, mcCmdWrite, mcCmdAddr, mcWdata, wdOverflow
  );
endinterface

// File: rtl/ring_mem_port.sv
// rtl/ring_mem_port.sv - memory-controller ring station: line commands, read return, exclusive grants
module ring_mem_port #(
  parameter int CMD_DEPTH = 16,
  parameter int WD_DEPTH  = 32,
  parameter int RING_LAT  = 16
) (
  input logic            clock,
  input logic            reset,
  ring_mem_port_if.slave bus
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int WAW = $clog2(WD_DEPTH);
  localparam int WCW = $clog2(WD_DEPTH + 1);
  localparam int PCW = $clog2(RING_LAT + 1);

  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;
  localparam logic [3:0] SLOT_GRANT = 4'd6;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  // slot decode
  logic isAddr, isUpgrade, isRead, isWrite, isWdata, isNull;
  logic readNack, readAccept, upgNack, upgAccept, grantEmit;

  // snoop-hold delay pipe for reads
  logic [RING_LAT-1:0] pipeValid;
  logic [31:0]         pipeData [RING_LAT];
  logic [PCW-1:0]      pipeOcc;
  logic                pipeExit;

  // command FIFO: {write, src[3:0], lineAddr[27:0]}
  logic [32:0]    cmdMem [CMD_DEPTH];
  logic [CAW-1:0] cmdWp, cmdRp, cmdWp1, cmdWp2, cmdRp1;
  logic [CCW-1:0] cmdCount;
  logic [32:0]    cmdHead;
  logic           cmdNonEmpty, cmdValid, cmdPop, cmdWrPush, cmdRdPush;
  int             cmdRoom;

  // write-data FIFO
  logic [31:0]    wdMem [WD_DEPTH];
  logic [WAW-1:0] wdWp, wdRp;
  logic [WCW-1:0] wdCount;
  logic           wdFull, wdPush, wdPop;

  // grant queue (4 entries of source ids)
  logic [3:0] gqMem [4];
  logic [1:0] gqWp, gqRp;
  logic [2:0] gqCount;
  logic       gqFull;

  // rdTag FIFO (8 entries of source ids awaiting read data)
  logic [3:0] rtMem [8];
  logic [2:0] rtWp, rtRp;
  logic [3:0] rtCount;
  logic       rtFull, rtPush, rtPop, rdTake;
  logic [2:0] rdCnt;

  // count reads currently held in the delay pipe
  always_comb begin
    pipeOcc = '0;
    for (int i = 0; i < RING_LAT; i++) pipeOcc = pipeOcc + PCW'(pipeValid[i]);
  end

  // classify the incoming slot and decide nacks; reads keep one command entry free for writes
  always_comb begin
    isAddr     = (bus.SlotTypeIn == SLOT_ADDR) && (bus.SourceIn != 4'd0) && !bus.RingIn[31];
    isUpgrade  = isAddr && bus.RingIn[28] && bus.RingIn[30];
    isRead     = isAddr && bus.RingIn[28] && !bus.RingIn[30];
    isWrite    = isAddr && !bus.RingIn[28];
    isWdata    = (bus.SlotTypeIn == SLOT_WDATA) && (bus.SourceIn != 4'd0);
    isNull     = (bus.SlotTypeIn == SLOT_NULL);
    readNack   = isRead && ((int'(cmdCount) + int'(pipeOcc) + 2) > CMD_DEPTH);
    readAccept = isRead && !readNack;
    gqFull     = (gqCount == 3'd4);
    upgNack    = isUpgrade && gqFull;
    upgAccept  = isUpgrade && !gqFull;
    grantEmit  = isNull && (gqCount != 3'd0);
  end

  // registered forwarding stage; a pending grant replaces a Null slot
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.RingOut     <= '0;
      bus.SlotTypeOut <= '0;
      bus.SourceOut   <= '0;
    end else if (grantEmit) begin
      bus.RingOut     <= '0;
      bus.SlotTypeOut <= SLOT_GRANT;
      bus.SourceOut   <= gqMem[gqRp];
    end else begin
      bus.RingOut     <= {bus.RingIn[31] | readNack | upgNack, bus.RingIn[30:0]};
      bus.SlotTypeOut <= bus.SlotTypeIn;
      bus.SourceOut   <= bus.SourceIn;
    end
  end

  // delay pipe valid bits shift one stage per cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      pipeValid <= '0;
    end else begin
      pipeValid[0] <= readAccept;
      for (int i = 1; i < RING_LAT; i++) pipeValid[i] <= pipeValid[i-1];
    end
  end

  // delay pipe payload follows the valid bits; payload of empty stages is don't-care
  always_ff @(posedge clock) begin
    pipeData[0] <= {bus.SourceIn, bus.RingIn[27:0]};
    for (int i = 1; i < RING_LAT; i++) pipeData[i] <= pipeData[i-1];
  end

  assign pipeExit = pipeValid[RING_LAT-1];

  // command FIFO head and issue gating: a read head waits while rdTag is full
  assign cmdHead     = cmdMem[cmdRp];
  assign cmdNonEmpty = (cmdCount != '0);
  assign cmdValid    = cmdNonEmpty && !(!cmdHead[32] && rtFull);
  assign cmdPop      = cmdValid && bus.mcCmdReady;

  assign bus.mcCmdValid = cmdValid;
  assign bus.mcCmdWrite = cmdNonEmpty && cmdHead[32];
  assign bus.mcCmdAddr  = cmdNonEmpty ? cmdHead[27:0] : '0;

  // command FIFO push decisions: ring write first, then the read leaving the delay pipe
  always_comb begin
    cmdRoom   = CMD_DEPTH - int'(cmdCount) + (cmdPop ? 1 : 0);
    cmdWrPush = isWrite && (cmdRoom >= 1);
    cmdRdPush = pipeExit && (cmdRoom >= (cmdWrPush ? 2 : 1));
    cmdWp1    = (cmdWp  == CAW'(CMD_DEPTH - 1)) ? '0 : cmdWp  + CAW'(1);
    cmdWp2    = (cmdWp1 == CAW'(CMD_DEPTH - 1)) ? '0 : cmdWp1 + CAW'(1);
    cmdRp1    = (cmdRp  == CAW'(CMD_DEPTH - 1)) ? '0 : cmdRp  + CAW'(1);
  end

  // command FIFO storage; up to two entries written per cycle
  always_ff @(posedge clock) begin
    if (cmdWrPush) cmdMem[cmdWp] <= {1'b1, bus.SourceIn, bus.RingIn[27:0]};
    if (cmdRdPush) cmdMem[cmdWrPush ? cmdWp1 : cmdWp] <= {1'b0, pipeData[RING_LAT-1]};
  end

  // command FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      cmdWp    <= '0;
      cmdRp    <= '0;
      cmdCount <= '0;
    end else begin
      if (cmdWrPush && cmdRdPush)      cmdWp <= cmdWp2;
      else if (cmdWrPush || cmdRdPush) cmdWp <= cmdWp1;
      if (cmdPop) cmdRp <= cmdRp1;
      cmdCount <= cmdCount + CCW'(cmdWrPush) + CCW'(cmdRdPush) - CCW'(cmdPop);
    end
  end

  // write-data FIFO control; a word arriving while full is dropped
  assign wdFull      = (wdCount == WCW'(WD_DEPTH));
  assign wdPush      = isWdata && !wdFull;
  assign wdPop       = bus.mcWdataPop && (wdCount != '0);
  assign bus.mcWdata = (wdCount != '0) ? wdMem[wdRp] : '0;

  // write-data FIFO storage
  always_ff @(posedge clock) begin
    if (wdPush) wdMem[wdWp] <= bus.RingIn;
  end

  // write-data FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wdWp           <= '0;
      wdRp           <= '0;
      wdCount        <= '0;
      bus.wdOverflow <= 1'b0;
    end else begin
      if (wdPush) wdWp <= (wdWp == WAW'(WD_DEPTH - 1)) ? '0 : wdWp + WAW'(1);
      if (wdPop)  wdRp <= (wdRp == WAW'(WD_DEPTH - 1)) ? '0 : wdRp + WAW'(1);
      wdCount <= wdCount + WCW'(wdPush) - WCW'(wdPop);
      if (isWdata && wdFull) bus.wdOverflow <= 1'b1;
    end
  end

  // grant queue: upgrades push their source, Null slots drain it
  always_ff @(posedge clock) begin
    if (reset) begin
      gqWp    <= '0;
      gqRp    <= '0;
      gqCount <= '0;
    end else begin
      if (upgAccept) begin
        gqMem[gqWp] <= bus.SourceIn;
        gqWp        <= gqWp + 2'd1;
      end
      if (grantEmit) gqRp <= gqRp + 2'd1;
      gqCount <= gqCount + 3'(upgAccept) - 3'(grantEmit);
    end
  end

  // rdTag bookkeeping: push on read acceptance, pop after the eighth returned word
  assign rtFull = (rtCount == 4'd8);
  assign rtPush = cmdPop && !cmdHead[32];
  assign rdTake = bus.mcRdataValid && (rtCount != 4'd0);
  assign rtPop  = rdTake && (rdCnt == 3'd7);

  // rdTag FIFO storage and pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      rtWp    <= '0;
      rtRp    <= '0;
      rtCount <= '0;
    end else begin
      if (rtPush) begin
        rtMem[rtWp] <= cmdHead[31:28];
        rtWp        <= rtWp + 3'd1;
      end
      if (rtPop) rtRp <= rtRp + 3'd1;
      rtCount <= rtCount + 4'(rtPush) - 4'(rtPop);
    end
  end

  // read return: registered word and destination, zero when nothing is returning
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.RDreturn <= '0;
      bus.RDdest   <= '0;
      rdCnt        <= '0;
    end else if (rdTake) begin
      bus.RDreturn <= bus.mcRdata;
      bus.RDdest   <= rtMem[rtRp];
      rdCnt        <= rdCnt + 3'd1;
    end else begin
      bus.RDreturn <= '0;
      bus.RDdest   <= '0;
    end
  end
endmodule

// File: tb/tb_ring_mem_port.sv
// tb/tb_ring_mem_port.sv - directed self-checking bench for ring_mem_port
module tb_ring_mem_port;
  localparam int RING_LAT = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  ring_mem_port_if bus ();

  ring_mem_port #(.CMD_DEPTH(16), .WD_DEPTH(32), .RING_LAT(RING_LAT)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendSlot(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    bus.SlotTypeIn = t;
    bus.SourceIn   = s;
    bus.RingIn     = d;
    tick();
    bus.SlotTypeIn = 4'd0;
    bus.SourceIn   = 4'd0;
    bus.RingIn     = 32'd0;
  endtask

  task automatic waitCmd(input string tag);
    int n = 0;
    while (!bus.mcCmdValid && n < 8) begin
      tick();
      n++;
    end
    chk(tag, bus.mcCmdValid, 1);
  endtask

  task automatic popCmd;
    bus.mcCmdReady = 1'b1;
    tick();
    bus.mcCmdReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.RingIn = '0; bus.SlotTypeIn = '0; bus.SourceIn = '0;
    bus.mcCmdReady = 1'b0; bus.mcWdataPop = 1'b0;
    bus.mcRdata = '0; bus.mcRdataValid = 1'b0;
    tick(); tick();
    chk("rst_ringout", bus.RingOut, 0);
    chk("rst_slottype", bus.SlotTypeOut, 0);
    chk("rst_rddest", bus.RDdest, 0);
    chk("rst_cmdvalid", bus.mcCmdValid, 0);
    chk("rst_overflow", bus.wdOverflow, 0);
    reset = 1'b0;
    tick();

    // 1: core 2 line read, held RING_LAT cycles, 8 words returned to core 2
    sendSlot(4'd2, 4'd2, 32'h1000_0040);
    chk("t1_fwd_ring", bus.RingOut, 32'h1000_0040);
    chk("t1_fwd_type", bus.SlotTypeOut, 2);
    chk("t1_fwd_src", bus.SourceOut, 2);
    repeat (RING_LAT - 2) tick();
    chk("t1_not_early", bus.mcCmdValid, 0);
    waitCmd("t1_cmd_valid");
    chk("t1_cmd_addr", bus.mcCmdAddr, 32'h40);
    chk("t1_cmd_write", bus.mcCmdWrite, 0);
    popCmd();
    chk("t1_cmd_empty", bus.mcCmdValid, 0);
    for (int i = 0; i < 8; i++) begin
      bus.mcRdata = 32'hD000_0000 + i;
      bus.mcRdataValid = 1'b1;
      tick();
      chk("t1_rddest", bus.RDdest, 2);
      chk("t1_rdreturn", bus.RDreturn, 32'hD000_0000 + i);
    end
    bus.mcRdataValid = 1'b0;
    tick();
    chk("t1_rddest_idle", bus.RDdest, 0);

    // 2: core 3 writes a line of data then flushes 0x123
    for (int i = 0; i < 8; i++) sendSlot(4'd3, 4'd3, 32'hA0 + i);
    sendSlot(4'd2, 4'd3, 32'h0000_0123);
    chk("t2_cmd_valid", bus.mcCmdValid, 1);
    chk("t2_cmd_write", bus.mcCmdWrite, 1);
    chk("t2_cmd_addr", bus.mcCmdAddr, 32'h123);
    popCmd();
    for (int i = 0; i < 8; i++) begin
      chk("t2_wdata", bus.mcWdata, 32'hA0 + i);
      bus.mcWdataPop = 1'b1;
      tick();
      bus.mcWdataPop = 1'b0;
    end
    chk("t2_cmd_empty", bus.mcCmdValid, 0);

    // 3: core 4 exclusive upgrade, granted on the next Null slot
    sendSlot(4'd2, 4'd4, 32'h5000_0010);
    chk("t3_fwd_upg", bus.RingOut, 32'h5000_0010);
    for (int i = 0; i < 3; i++) begin
      sendSlot(4'd2, 4'd1, 32'h9000_0100 + i);
      chk("t3_passthru", bus.RingOut, 32'h9000_0100 + i);
    end
    sendSlot(4'd7, 4'd0, 32'h1234_5678);
    chk("t3_grant_type", bus.SlotTypeOut, 6);
    chk("t3_grant_src", bus.SourceOut, 4);
    chk("t3_grant_ring", bus.RingOut, 0);
    chk("t3_no_cmd", bus.mcCmdValid, 0);
    sendSlot(4'd7, 4'd0, 32'h0000_0055);
    chk("t3_null_type", bus.SlotTypeOut, 7);
    chk("t3_null_ring", bus.RingOut, 32'h55);

    // 4: fill to CMD_DEPTH-1, read nacked, write still accepted
    for (int i = 0; i < 15; i++) sendSlot(4'd2, 4'd6, 32'h0000_0300 + i);
    sendSlot(4'd2, 4'd2, 32'h1000_0400);
    chk("t4_read_nack", bus.RingOut, 32'h9000_0400);
    sendSlot(4'd2, 4'd6, 32'h0000_0500);
    chk("t4_write_fwd", bus.RingOut, 32'h0000_0500);
    repeat (RING_LAT + 4) tick();
    bus.mcCmdReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain_write", bus.mcCmdWrite, 1);
      chk("t4_drain_addr", bus.mcCmdAddr, (i < 15) ? 32'h300 + i : 32'h500);
      tick();
    end
    bus.mcCmdReady = 1'b0;
    chk("t4_drain_empty", bus.mcCmdValid, 0);

    // 5: read of a line, flush of the same line 4 cycles later reaches memory first
    sendSlot(4'd2, 4'd2, 32'h1000_0200);
    repeat (3) tick();
    sendSlot(4'd2, 4'd5, 32'h2000_0200);
    repeat (RING_LAT + 4) tick();
    chk("t5_first_write", bus.mcCmdWrite, 1);
    chk("t5_first_addr", bus.mcCmdAddr, 32'h200);
    popCmd();
    chk("t5_second_valid", bus.mcCmdValid, 1);
    chk("t5_second_write", bus.mcCmdWrite, 0);
    chk("t5_second_addr", bus.mcCmdAddr, 32'h200);
    popCmd();

    // write-data overflow: 33 words into a 32-word FIFO
    for (int i = 0; i < 32; i++) sendSlot(4'd3, 4'd7, 32'hB00 + i);
    chk("ovf_not_yet", bus.wdOverflow, 0);
    sendSlot(4'd3, 4'd7, 32'hBFF);
    chk("ovf_set", bus.wdOverflow, 1);
    chk("ovf_head", bus.mcWdata, 32'hB00);

    // 6: reset in the middle of a read return
    for (int i = 0; i < 3; i++) begin
      bus.mcRdata = 32'hE0 + i;
      bus.mcRdataValid = 1'b1;
      tick();
      chk("t6_rddest", bus.RDdest, 2);
    end
    reset = 1'b1;
    bus.mcRdata = 32'hE3;
    tick();
    chk("t6_rst_rddest", bus.RDdest, 0);
    chk("t6_rst_rdreturn", bus.RDreturn, 0);
    chk("t6_rst_cmdvalid", bus.mcCmdValid, 0);
    chk("t6_rst_overflow", bus.wdOverflow, 0);
    chk("t6_rst_wdata", bus.mcWdata, 0);
    reset = 1'b0;
    tick();
    chk("t6_rdtag_empty", bus.RDdest, 0);
    bus.mcRdataValid = 1'b0;
    tick();

    // grant queue full: the fifth upgrade is nacked, four grants drain in order
    for (int c = 1; c <= 5; c++) begin
      sendSlot(4'd2, 4'(c), 32'h5000_0020);
      chk("gq_upg_fwd", bus.RingOut, (c == 5) ? 32'hD000_0020 : 32'h5000_0020);
    end
    for (int c = 1; c <= 4; c++) begin
      sendSlot(4'd7, 4'd0, 32'h0);
      chk("gq_grant_type", bus.SlotTypeOut, 6);
      chk("gq_grant_src", bus.SourceOut, c);
    end
    sendSlot(4'd7, 4'd0, 32'h77);
    chk("gq_drained", bus.SlotTypeOut, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
